// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int unsigned SERIAL_SUB_W_DEF = 4;

endpackage

// File: rtl/Full_Subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, bout is the borrow out.
module Full_Subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor d = x - y, LSB first, WIDTH cycles per result.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_SUB_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] xs_q, ys_q, res_q, d_q;
  logic [CntW-1:0]  cnt_q;
  logic             borrow_q, b_out_q;
  logic             cell_diff, cell_bout;
  logic [WIDTH-1:0] res_next;
  logic             accept, last;

  Full_Subtractor u_cell (
    .a    (xs_q[0]),
    .b    (ys_q[0]),
    .bin  (borrow_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  assign res_next = {cell_diff, res_q[WIDTH-1:1]};
  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign last     = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs_q     <= '0;
      ys_q     <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      d_q      <= '0;
      b_out_q  <= 1'b0;
    end else if (accept) begin
      xs_q     <= x;
      ys_q     <= y;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      xs_q     <= xs_q >> 1;
      ys_q     <= ys_q >> 1;
      res_q    <= res_next;
      cnt_q    <= cnt_q + 1'b1;
      borrow_q <= cell_bout;
      // Holding registers only see completed results.
      if (last) begin
        d_q     <= res_next;
        b_out_q <= cell_bout;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand signs are shifted out of xs/ys, so they are kept separately.
  logic x_sign_q, y_sign_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sign_q <= 1'b0;
      y_sign_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      x_sign_q <= x[WIDTH-1];
      y_sign_q <= y[WIDTH-1];
    end else if ((state_q == SHIFT) && last) begin
      ovf_q <= (x_sign_q != y_sign_q) && (res_next[WIDTH-1] != x_sign_q);
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign d     = d_q;
  assign b_out = b_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4); ovf checks when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         busy, done, b_out;
  logic [W-1:0] d;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch at a negedge, accept on the next posedge (T), sample on negedges T+1..T+6.
  task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] ya,
                        input logic [W-1:0] exp_d, input logic exp_b);
    x     = xa;
    y     = ya;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy@T+1"}, 32'(busy), 32'd1);
    check({tag, " done@T+1"}, 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, " busy@T+4"}, 32'(busy), 32'd1);
    check({tag, " done@T+4"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, " done@T+5"}, 32'(done), 32'd1);
    check({tag, " busy@T+5"}, 32'(busy), 32'd0);
    check({tag, " d"}, 32'(d), 32'(exp_d));
    check({tag, " b_out"}, 32'(b_out), 32'(exp_b));
    @(negedge clk);
    check({tag, " done@T+6"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic seen_done;

    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset d", 32'(d), 32'd0);
    check("reset b_out", 32'(b_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("9-3", 4'd9, 4'd3, 4'd6, 1'b0);
    run_op("3-9", 4'd3, 4'd9, 4'hA, 1'b1);
    run_op("5-5", 4'd5, 4'd5, 4'd0, 1'b0);
    run_op("0-0", 4'd0, 4'd0, 4'd0, 1'b0);

    // 8-2 with a start pulse mid-shift, then 15-1 launched from DONE.
    x = 4'd8; y = 4'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    x = 4'd1; y = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("8-2 busy@T+4", 32'(busy), 32'd1);
    @(negedge clk);
    check("8-2 done", 32'(done), 32'd1);
    check("8-2 d", 32'(d), 32'd6);
    check("8-2 b_out", 32'(b_out), 32'd0);
    x = 4'd15; y = 4'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("8-2 done once", 32'(done), 32'd0);
    check("15-1 busy", 32'(busy), 32'd1);
    check("15-1 d held", 32'(d), 32'd6);
    repeat (3) @(negedge clk);
    check("15-1 done early", 32'(done), 32'd0);
    @(negedge clk);
    check("15-1 done", 32'(done), 32'd1);
    check("15-1 d", 32'(d), 32'd14);
    check("15-1 b_out", 32'(b_out), 32'd0);
    @(negedge clk);

    // Reset mid-operation: outputs clear at once and the discarded op never completes.
    x = 4'd9; y = 4'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst d", 32'(d), 32'd0);
    check("rst b_out", 32'(b_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("rst no done", 32'(seen_done), 32'd0);

`ifdef SERIAL_SUB_OVF_EN
    run_op("7-F", 4'd7, 4'hF, 4'h8, 1'b1);
    check("7-F ovf", 32'(ovf), 32'd1);
    run_op("8-1", 4'h8, 4'd1, 4'h7, 1'b0);
    check("8-1 ovf", 32'(ovf), 32'd1);
    run_op("6-2", 4'd6, 4'd2, 4'd4, 1'b0);
    check("6-2 ovf", 32'(ovf), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Bit-serial unsigned subtractor: computes `d = x - y` over `WIDTH` cycles, LSB first.
- Uses one full-subtractor cell and a borrow flip-flop.
- Pairs with the team's parallel adder datapaths as their inverse operation.
- Serves area-constrained paths where subtraction latency is acceptable; a start/busy/done handshake makes it easy to sequence from a controller.

## Interface
- `WIDTH`, default 4: operand and result width; legal range 2..32.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request; sampled only in IDLE or DONE.
- `x` input, `WIDTH` bits: minuend; sampled on the accepted `start` edge only.
- `y` input, `WIDTH` bits: subtrahend; sampled on the accepted `start` edge only.
- `busy` output, 1 bit: high while a subtraction is in progress.
- `done` output, 1 bit: one-cycle pulse when `d` and `b_out` are updated.
- `d` output, `WIDTH` bits: difference, `(x - y) mod 2^WIDTH`.
- `b_out` output, 1 bit: final borrow; 1 when `x < y` unsigned.
- `ovf` output, 1 bit: signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- **FSM states**
  - IDLE → SHIFT on `start`.
  - SHIFT → DONE when the bit counter reaches `WIDTH-1`.
  - DONE → SHIFT on `start`, otherwise DONE → IDLE.
- **On accept**
  - Load `x` and `y` into shift registers.
  - Clear the borrow flop and the bit counter.
  - Clear the internal result shift register.
- **Each SHIFT cycle**
  - Cell inputs: `a = xs[0]`, `b = ys[0]`, `bin = borrow`.
  - Cell outputs: `diff = a^b^bin`, `bout = (~a&b) | (~(a^b)&bin)`.
  - Shift `diff` into the result register MSB. Shift `xs` and `ys` right. Update `borrow <= bout`. Increment the counter.
- **Last SHIFT cycle**
  - Load the output holding registers `d` and `b_out` (and `ovf`) from the completed result and final borrow.
  - Assert `done` in the next cycle (DONE state).
- **Output hold**
  - `d` and `b_out` hold their last result until the next DONE.
  - They never show partial results.
- **Start while busy:** `start` in SHIFT is ignored; no queueing, no error.
- **Reset mid-operation**
  - FSM returns to IDLE immediately; the in-flight operation is discarded.
  - No `done` is produced for the discarded operation.
- **Reset values:** `busy` = 0, `done` = 0, `d` = 0, `b_out` = 0, `ovf` = 0. Internal registers are also 0.
- **Width rules**
  - Counter width is `$clog2(WIDTH)`.
  - No saturation; the result wraps modulo `2^WIDTH`.

## Timing
- **Accept edge:** `start` sampled high at rising edge T.
- **`busy`:** high in cycles T+1 … T+WIDTH (registered, derived from state == SHIFT).
- **`done`, `d`, `b_out`:** `done` is high for exactly one cycle, T+WIDTH+1. `d` and `b_out` change on that same edge.
- **Back-to-back:** `start` held high during DONE is accepted, giving a throughput of one result per `WIDTH+1` cycles.
- **Outputs:** all registered; no combinational path from inputs to outputs.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - The `ovf` port exists.
  - `ovf = (x[MSB] != y[MSB]) && (d[MSB] != x[MSB])`.
  - Operand sign bits are captured at accept.
  - `ovf` updates with `d` and resets to 0.
- `SERIAL_SUB_OVF_EN` undefined: the `ovf` port and its sign-capture flops are absent; behaviour is otherwise identical.

## Structure
- **Shared package `serial_arith_pkg`**
  - State typedef `sub_state_t` {IDLE, SHIFT, DONE}.
  - Default width constant `SERIAL_SUB_W_DEF = 4`.
- **Sub-module `Full_Subtractor`**
  - Ports `(a, b, bin, diff, bout)`; purely combinational.
  - One instance inside `serial_subtractor`.

## Test plan
- **9 − 3:** `x=4'd9`, `y=4'd3`, start at T → `busy` high T+1..T+4; `done` at T+5 with `d=4'd6`, `b_out=0`.
- **3 − 9:** `x=4'd3`, `y=4'd9` → `d=4'hA`, `b_out=1`.
- **Equal and zero operands:** `5−5` and `0−0` → `d=0`, `b_out=0`.
- **Busy-start and back-to-back**
  - Pulse `start` with `x=1`, `y=1` during SHIFT of an `8−2` operation → ignored; `done` once with `d=6`.
  - Then hold `start` through DONE with `15−1` → `d=14` exactly 5 cycles later.
- **Reset mid-operation:** assert `rst_n=0` at T+2 → all outputs 0 immediately; no `done` pulse after release.
- **Overflow (`SERIAL_SUB_OVF_EN`)**
  - `7 − 4'hF` → `d=4'h8`, `ovf=1`.
  - `4'h8 − 1` → `d=4'h7`, `ovf=1`.
  - `6 − 2` → `ovf=0`.
